// File: rtl/vga_frame_fetch.sv
// Wishbone read master that fetches one frame of 12-bit pixels into a show-ahead FIFO.
// One bus transaction at most is outstanding; the master stalls while the FIFO is full.
module vga_frame_fetch #(
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        frame_start_i,
    input  logic [31:0] base_addr_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        pix_rd_i,
    output logic [11:0] pix_data_o,
    output logic        pix_valid_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int unsigned PW  = 12;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned WCW = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0]  FULL = CW'(FIFO_DEPTH);
    localparam logic [WCW-1:0] LAST = WCW'(FRAME_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           err_q, err_d;

    logic [PW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  occ_q, occ_d, occ_kept;
    logic [PW-1:0]  head_q, head_d;
    logic           push, pop;

    logic           cyc_q, busy_q, valid_q;
    logic           dat_unused;

    assign dat_unused = ^wbm_dat_i[31:PW];

    // FIFO bookkeeping; the head register is refreshed so the next pixel shows one cycle after its ack
    always_comb begin
        push     = (state_q == READ) && wbm_ack_i && !wbm_err_i;
        pop      = pix_rd_i && (occ_q != '0);
        occ_kept = occ_q - CW'(pop);
        occ_d    = occ_kept + CW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        head_d   = head_q;
        if (push && (occ_kept == '0)) begin
            head_d = wbm_dat_i[PW-1:0];
        end else if (occ_kept != '0) begin
            head_d = mem[rd_ptr_d];
        end
    end

    // Fetch sequencing; a frame start with a full FIFO waits in STALL so nothing is ever overwritten
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    addr_d  = base_addr_i;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                    state_d = (occ_d == FULL) ? STALL : READ;
                end
            end
            READ: begin
                if (wbm_err_i) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (wbm_ack_i) begin
                    addr_d = addr_q + 32'd4;
                    wcnt_d = wcnt_q + WCW'(1);
                    if (wcnt_d == LAST) begin
                        state_d = IDLE;
                    end else if (occ_d == FULL) begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (occ_q < FULL) begin
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wcnt_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            cyc_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            cyc_q    <= (state_d == READ);
            busy_q   <= (state_d != IDLE);
            valid_q  <= (occ_d != '0);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wbm_dat_i[PW-1:0];
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_adr_o   = addr_q;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = 4'hF;
    assign pix_data_o  = head_q;
    assign pix_valid_o = valid_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_vga_frame_fetch.sv
// Bench for vga_frame_fetch: frame-level model (expected address stream, pixel queue, flags)
// with a randomized Wishbone slave and consumer, a table of frames, and directed corner sequences.
module tb_vga_frame_fetch;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned FW_A  = 8;
    localparam int unsigned FW_B  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [31:0] base_addr;
    logic        ack, err, pix_rd;
    logic [31:0] dat;
    bit          dut_sel;

    logic        cyc_a, stb_a, we_a, vld_a, busy_a, erro_a;
    logic        cyc_b, stb_b, we_b, vld_b, busy_b, erro_b;
    logic [31:0] adr_a, adr_b;
    logic [3:0]  sel_a, sel_b;
    logic [11:0] pix_a, pix_b;

    logic        cyc, stb, we, pix_valid, busy, err_o;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [11:0] pix_data;

    always #5 clk = ~clk;

    vga_frame_fetch #(.FRAME_WORDS(FW_A), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .frame_start_i(frame_start && !dut_sel),
        .base_addr_i(base_addr), .wbm_cyc_o(cyc_a), .wbm_stb_o(stb_a), .wbm_adr_o(adr_a),
        .wbm_we_o(we_a), .wbm_sel_o(sel_a), .wbm_dat_i(dat), .wbm_ack_i(ack && !dut_sel),
        .wbm_err_i(err && !dut_sel), .pix_rd_i(pix_rd && !dut_sel), .pix_data_o(pix_a),
        .pix_valid_o(vld_a), .busy_o(busy_a), .err_o(erro_a));

    vga_frame_fetch #(.FRAME_WORDS(FW_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .frame_start_i(frame_start && dut_sel),
        .base_addr_i(base_addr), .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_adr_o(adr_b),
        .wbm_we_o(we_b), .wbm_sel_o(sel_b), .wbm_dat_i(dat), .wbm_ack_i(ack && dut_sel),
        .wbm_err_i(err && dut_sel), .pix_rd_i(pix_rd && dut_sel), .pix_data_o(pix_b),
        .pix_valid_o(vld_b), .busy_o(busy_b), .err_o(erro_b));

    assign cyc       = dut_sel ? cyc_b  : cyc_a;
    assign stb       = dut_sel ? stb_b  : stb_a;
    assign adr       = dut_sel ? adr_b  : adr_a;
    assign we        = dut_sel ? we_b   : we_a;
    assign sel       = dut_sel ? sel_b  : sel_a;
    assign pix_data  = dut_sel ? pix_b  : pix_a;
    assign pix_valid = dut_sel ? vld_b  : vld_a;
    assign busy      = dut_sel ? busy_b : busy_a;
    assign err_o     = dut_sel ? erro_b : erro_a;

    int checks, errors;

    // Model state: pixels the consumer has yet to see, next bus address, frame flags
    logic [11:0] exp_q[$];
    logic [31:0] exp_adr;
    bit          exp_busy, exp_err;
    int          n_acks, pop_cnt;

    // Slave / consumer policy, set by the main sequence
    int ack_prob, rd_prob, err_at, rd_force;
    bit late_ack;

    // Snapshot of the previous falling edge: what the DUT saw at the rising edge in between
    bit          p_ok, p_start, p_cyc, p_ack, p_err, p_rd, p_vld, p_stall;
    logic [31:0] p_base, p_dat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = {a[31:12] ^ 20'hA5C3E, a[13:2] ^ 12'h5A3};
    endfunction

    function automatic int frame_words();
        frame_words = dut_sel ? FW_B : FW_A;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_busy = 1'b0;
            exp_err  = 1'b0;
            n_acks   = 0;
            p_ok     = 1'b0;
            ack      = 1'b0;
            err      = 1'b0;
            pix_rd   = 1'b0;
            dat      = '0;
        end else begin
            if (p_ok) begin
                if (p_start && !exp_busy) begin
                    exp_busy = 1'b1;
                    exp_err  = 1'b0;
                    exp_adr  = p_base;
                    n_acks   = 0;
                end
                if (p_rd && p_vld && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    pop_cnt++;
                end
                if (p_cyc && p_err) begin
                    exp_err  = 1'b1;
                    exp_busy = 1'b0;
                end else if (p_cyc && p_ack) begin
                    exp_q.push_back(p_dat[11:0]);
                    exp_adr = exp_adr + 32'd4;
                    n_acks++;
                    if (n_acks == frame_words()) exp_busy = 1'b0;
                end
                if (p_stall) chk("stall_exit_cyc", cyc, 1);
            end
            chk("pix_valid", pix_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("pix_data", pix_data, exp_q[0]);
            chk("busy", busy, exp_busy);
            chk("err_o", err_o, exp_err);
            chk("stb_eq_cyc", stb, cyc);
            chk("we_sel", {we, sel}, 5'h0F);
            if (cyc) chk("adr", adr, exp_adr);
            if (exp_q.size() >= DEPTH) chk("full_cyc_low", cyc, 0);
            chk("occ_bound", exp_q.size() <= DEPTH, 1);

            ack = 1'b0;
            err = 1'b0;
            dat = $urandom;
            if (late_ack) begin
                ack      = 1'b1;
                late_ack = 1'b0;
            end else if (cyc && ($urandom_range(99) < ack_prob)) begin
                if (err_at != 0 && n_acks + 1 == err_at) begin
                    err = 1'b1;
                    ack = 1'($urandom_range(1));
                end else begin
                    ack = 1'b1;
                    dat = mem_word(adr);
                end
            end
            if (rd_force > 0) begin
                pix_rd = 1'b1;
                rd_force--;
            end else begin
                pix_rd = ($urandom_range(99) < rd_prob);
            end

            p_ok    = 1'b1;
            p_start = frame_start;
            p_base  = base_addr;
            p_cyc   = cyc;
            p_ack   = ack;
            p_err   = err;
            p_dat   = dat;
            p_rd    = pix_rd;
            p_vld   = pix_valid;
            p_stall = busy && !cyc && (exp_q.size() < DEPTH);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic start_frame(input logic [31:0] b);
        step();
        base_addr   = b;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        chk("frame_done", busy, 0);
        step();
    endtask

    task automatic drain(output int left);
        pop_cnt = 0;
        rd_prob = 100;
        repeat (DEPTH + 4) step();
        rd_prob = 0;
        step();
        left = pop_cnt;
    endtask

    typedef struct {
        bit          sel;
        logic [31:0] base;
        int          ack_p;
        int          rd_p;
        int          err_at;
        int          exp_acks;
        bit          exp_err;
        int          exp_left;
    } row_t;

    row_t        rows[11];
    int          left;
    logic [31:0] rb;

    initial begin
        rst = 1'b0; frame_start = 1'b0; base_addr = '0; dut_sel = 1'b0;
        ack = 1'b0; err = 1'b0; pix_rd = 1'b0; dat = '0;
        ack_prob = 100; rd_prob = 0; err_at = 0; rd_force = 0; late_ack = 1'b0;
        pop_cnt = 0; checks = 0; errors = 0; p_ok = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_cyc_stb", {cyc, stb}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_we_sel", {we, sel}, 5'h0F);
        chk("rst_valid_pix", {pix_valid, pix_data}, 0);
        chk("rst_busy_err", {busy, err_o}, 0);
        repeat (2) step();
        rst = 1'b0;
        step();

        rows[0] = '{1'b0, 32'h0000_1000, 100, 100, 0, FW_A, 1'b0, -1};
        rows[1] = '{1'b0, 32'hFFFF_FFF8, 100,   0, 0, FW_A, 1'b0, FW_A};
        rows[2] = '{1'b0, 32'h0000_2000, 100,   0, 3,    2, 1'b1, 2};
        rows[3] = '{1'b1, 32'h8000_0000,  60,  70, 0, FW_B, 1'b0, -1};
        rows[4] = '{1'b0, 32'h0000_0040,  50,   0, 1,    0, 1'b1, 0};
        for (int i = 5; i < 11; i++) begin
            rb = $urandom;
            rb[1:0] = 2'b00;
            rows[i].sel      = 1'($urandom_range(1));
            rows[i].base     = rb;
            rows[i].ack_p    = 30 + $urandom_range(70);
            rows[i].rd_p     = 40 + $urandom_range(60);
            rows[i].err_at   = 0;
            rows[i].exp_acks = rows[i].sel ? FW_B : FW_A;
            rows[i].exp_err  = 1'b0;
            rows[i].exp_left = -1;
        end

        for (int i = 0; i < 11; i++) begin
            do_reset();
            dut_sel  = rows[i].sel;
            ack_prob = rows[i].ack_p;
            rd_prob  = rows[i].rd_p;
            err_at   = rows[i].err_at;
            start_frame(rows[i].base);
            wait_idle(3000);
            chk("row_acks", n_acks, rows[i].exp_acks);
            chk("row_err", err_o, rows[i].exp_err);
            err_at = 0;
            if (rows[i].exp_left >= 0) begin
                drain(left);
                chk("row_left", left, rows[i].exp_left);
            end
        end

        // Stall at full, single-pop resume, then sustained pop alongside acks
        do_reset();
        dut_sel = 1'b1; ack_prob = 100; rd_prob = 0;
        start_frame(32'h0000_3000);
        pop_cnt = 0;
        for (int i = 0; i < 200 && cyc; i++) step();
        step();
        chk("stall_acks", n_acks, DEPTH);
        chk("stall_cyc", cyc, 0);
        repeat (5) step();
        chk("stall_hold_acks", n_acks, DEPTH);
        chk("stall_hold_busy", {busy, cyc}, 2'b10);
        rd_force = 1;
        repeat (6) step();
        chk("one_pop_one_txn", n_acks, DEPTH + 1);
        chk("one_pop_cyc", cyc, 0);
        rd_prob = 100;
        repeat (10) step();
        rd_prob = 0;
        repeat (10) step();
        chk("refill_cyc", {busy, cyc}, 2'b10);
        chk("refill_occ", n_acks - pop_cnt, DEPTH);
        rd_prob = 100;
        wait_idle(500);
        chk("full_frame_acks", n_acks, FW_B);
        drain(left);
        chk("drained_valid", pix_valid, 0);

        // Bus error keeps fetched pixels; the next frame clears the flag
        do_reset();
        dut_sel = 1'b0; ack_prob = 100; rd_prob = 0; err_at = 3;
        start_frame(32'h0000_2000);
        wait_idle(200);
        chk("err_set", err_o, 1);
        chk("err_acks", n_acks, 2);
        err_at = 0;
        start_frame(32'h0000_2100);
        chk("err_cleared", {busy, err_o}, 2'b10);
        wait_idle(200);
        chk("restart_acks", n_acks, FW_A);
        drain(left);
        chk("restart_left", left, FW_A + 2);

        // Reset while an ack is on the bus, then a stray ack after release
        do_reset();
        dut_sel = 1'b0; ack_prob = 100; rd_prob = 0;
        start_frame(32'h0000_5000);
        repeat (2) step();
        @(negedge clk);
        #2;
        chk("pre_rst_cyc_ack", {cyc, ack}, 2'b11);
        rst = 1'b1;
        #1;
        chk("async_cyc_stb", {cyc, stb}, 0);
        chk("async_busy", busy, 0);
        chk("async_fifo", {pix_valid, pix_data}, 0);
        chk("async_adr", adr, 0);
        step();
        step();
        rst = 1'b0;
        late_ack = 1'b1;
        repeat (3) step();
        chk("late_ack_valid", pix_valid, 0);
        chk("late_ack_idle", {busy, cyc}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
